// File: rtl/imul_iter_unit_pkg.sv
// Shared processor types: memory messages plus the iterative multiplier request,
// state encoding and default operand width.
package imul_iter_unit_pkg;

   localparam int unsigned IMUL_NBITS   = 32;
   localparam int unsigned MEM_ADDR_W   = 32;
   localparam int unsigned MEM_DATA_W   = 32;

   typedef enum logic [0:0] {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_type_e;

   typedef struct packed {
      mem_type_e               typ;
      logic [MEM_ADDR_W-1:0]   addr;
      logic [MEM_DATA_W-1:0]   data;
   } mem_req_t;

   typedef struct packed {
      mem_type_e               typ;
      logic [MEM_DATA_W-1:0]   data;
   } mem_resp_t;

   // Multiplier request payload; a occupies the upper half of req_msg.
   typedef struct packed {
      logic [IMUL_NBITS-1:0]   a;
      logic [IMUL_NBITS-1:0]   b;
   } imul_req_t;

   typedef enum logic [1:0] {
      IMUL_IDLE = 2'd0,
      IMUL_CALC = 2'd1,
      IMUL_DONE = 2'd2
   } imul_state_e;

   localparam logic [1:0] ST_IDLE = IMUL_IDLE;
   localparam logic [1:0] ST_CALC = IMUL_CALC;
   localparam logic [1:0] ST_DONE = IMUL_DONE;

endpackage

// File: rtl/imul_iter_unit_if.sv
// Request/response valid-ready bundle between decode/execute and the multiplier.
interface imul_iter_unit_if
   import imul_iter_unit_pkg::*;
#(
   parameter int unsigned NBITS = IMUL_NBITS
);
   logic               req_val;
   logic               req_rdy;
   logic [2*NBITS-1:0] req_msg;
   logic               resp_val;
   logic               resp_rdy;
   logic [NBITS-1:0]   resp_msg;

   modport master (
      output req_val, req_msg, resp_rdy,
      input  req_rdy, resp_val, resp_msg
   );

   modport slave (
      input  req_val, req_msg, resp_rdy,
      output req_rdy, resp_val, resp_msg
   );
endinterface

// File: rtl/imul_iter_unit_dp.sv
// Shift-and-add datapath: operand registers, accumulator and adder.
// IMUL_EARLY_EXIT_EN exposes a flag telling the FSM the multiplier runs out of ones.
module imul_iter_dp
   import imul_iter_unit_pkg::*;
#(
   parameter int unsigned NBITS = IMUL_NBITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [NBITS-1:0] a_i,
   input  logic [NBITS-1:0] b_i,
`ifdef IMUL_EARLY_EXIT_EN
   output logic             b_next_zero_o,
`endif
   output logic [NBITS-1:0] acc_o
);

   logic [NBITS-1:0] a_q, a_d;
   logic [NBITS-1:0] b_q, b_d;
   logic [NBITS-1:0] acc_q, acc_d;

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (load_i) begin
         a_d   = a_i;
         b_d   = b_i;
         acc_d = '0;
      end else if (step_i) begin
         if (b_q[0]) acc_d = acc_q + a_q;
         a_d = a_q << 1;
         b_d = b_q >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

`ifdef IMUL_EARLY_EXIT_EN
   assign b_next_zero_o = ((b_q >> 1) == '0);
`endif
   assign acc_o = acc_q;

endmodule

// File: rtl/imul_iter_unit.sv
// Iterative unsigned/signed-low multiplier: IDLE -> CALC (one bit per cycle) -> DONE.
// Define IMUL_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier is zero.
module imul_iter_unit
   import imul_iter_unit_pkg::*;
#(
   parameter int unsigned NBITS = IMUL_NBITS
) (
   input  logic             clk,
   input  logic             reset,
   imul_iter_unit_if.slave  bus
);

   localparam int unsigned      CNT_W    = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_rdy_q, resp_val_q;
   logic             load_c, step_c, calc_last_c;
   logic [NBITS-1:0] acc;

`ifdef IMUL_EARLY_EXIT_EN
   logic b_next_zero_c;
   assign calc_last_c = (cnt_q == CNT_LAST) || b_next_zero_c;
`else
   assign calc_last_c = (cnt_q == CNT_LAST);
`endif

   imul_iter_dp #(.NBITS(NBITS)) u_dp (
      .clk           (clk),
      .rst_n         (reset),
      .load_i        (load_c),
      .step_i        (step_c),
      .a_i           (bus.req_msg[2*NBITS-1:NBITS]),
      .b_i           (bus.req_msg[NBITS-1:0]),
`ifdef IMUL_EARLY_EXIT_EN
      .b_next_zero_o (b_next_zero_c),
`endif
      .acc_o         (acc)
   );

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_c  = 1'b0;
      step_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_val) begin
               load_c  = 1'b1;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            step_c = 1'b1;
            if (calc_last_c) state_d = ST_DONE;
            else             cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_DONE: begin
            if (bus.resp_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_rdy_q  <= 1'b1;
         resp_val_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_rdy_q  <= (state_d == ST_IDLE);
         resp_val_q <= (state_d == ST_DONE);
      end
   end

   assign bus.req_rdy  = req_rdy_q;
   assign bus.resp_val = resp_val_q;
   assign bus.resp_msg = acc;

endmodule
